// File: rtl/bin_to_bcd_conv.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one operand bit per clock).
// Accepts unsigned or two's-complement input; registered bcd/neg/ovf held until next completion.
module bin_to_bcd_conv #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  st,
  input  logic                  sgn,
  input  logic [WIDTH-1:0]      num,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  neg,
  output logic                  ovf
);

  localparam int unsigned BW = 4 * DIGITS;
  localparam int unsigned CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LastStep = CW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StConv, StDone} state_e;

  state_e          state_q;
  logic [WIDTH-1:0] mag_q;
  logic [BW-1:0]    work_q;
  logic [CW-1:0]    cnt_q;
  logic             sticky_q;
  logic             neg_r_q;

  logic [BW-1:0]    adj;
  logic [BW-1:0]    shifted;
  logic             out_bit;

  // Digits >= 5 get +3 so the following left shift carries correctly into the next digit.
  always_comb begin
    adj = work_q;
    for (int k = 0; k < int'(DIGITS); k++) begin
      if (work_q[4*k +: 4] >= 4'd5) begin
        adj[4*k +: 4] = work_q[4*k +: 4] + 4'd3;
      end
    end
    shifted = {adj[BW-2:0], mag_q[WIDTH-1]};
    out_bit = adj[BW-1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      mag_q    <= '0;
      work_q   <= '0;
      cnt_q    <= '0;
      sticky_q <= 1'b0;
      neg_r_q  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bcd      <= '0;
      neg      <= 1'b0;
      ovf      <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done <= 1'b0;
          if (st) begin
            // Two's-complement negate in WIDTH bits; the most negative value maps to 2^(WIDTH-1).
            mag_q    <= (sgn && num[WIDTH-1]) ? (~num + WIDTH'(1)) : num;
            neg_r_q  <= sgn && num[WIDTH-1];
            work_q   <= '0;
            cnt_q    <= '0;
            sticky_q <= 1'b0;
            busy     <= 1'b1;
            state_q  <= StConv;
          end
        end
        StConv: begin
          work_q   <= shifted;
          mag_q    <= {mag_q[WIDTH-2:0], 1'b0};
          cnt_q    <= cnt_q + CW'(1);
          sticky_q <= sticky_q | out_bit;
          if (cnt_q == LastStep) begin
            bcd     <= shifted;
            ovf     <= sticky_q | out_bit;
            neg     <= neg_r_q;
            busy    <= 1'b0;
            done    <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done    <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_conv.sv
// Scoreboard bench for bin_to_bcd_conv: three configurations, directed and random operands
// checked against a decimal reference model; monitors pop expected results on each done.
module tb_bin_to_bcd_conv;

  typedef struct {
    logic [63:0] bcd;
    logic        neg;
    logic        ovf;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance 0: WIDTH=8 DIGITS=3
  logic        a_st = 1'b0, a_sgn = 1'b0, a_busy, a_done, a_neg, a_ovf;
  logic [7:0]  a_num = '0;
  logic [11:0] a_bcd;
  // Instance 1: WIDTH=8 DIGITS=2
  logic        b_st = 1'b0, b_sgn = 1'b0, b_busy, b_done, b_neg, b_ovf;
  logic [7:0]  b_num = '0;
  logic [7:0]  b_bcd;
  // Instance 2: WIDTH=16 DIGITS=5
  logic        c_st = 1'b0, c_sgn = 1'b0, c_busy, c_done, c_neg, c_ovf;
  logic [15:0] c_num = '0;
  logic [19:0] c_bcd;

  bin_to_bcd_conv #(.WIDTH(8), .DIGITS(3)) u_a (
    .clk(clk), .rst(rst), .st(a_st), .sgn(a_sgn), .num(a_num),
    .busy(a_busy), .done(a_done), .bcd(a_bcd), .neg(a_neg), .ovf(a_ovf)
  );
  bin_to_bcd_conv #(.WIDTH(8), .DIGITS(2)) u_b (
    .clk(clk), .rst(rst), .st(b_st), .sgn(b_sgn), .num(b_num),
    .busy(b_busy), .done(b_done), .bcd(b_bcd), .neg(b_neg), .ovf(b_ovf)
  );
  bin_to_bcd_conv #(.WIDTH(16), .DIGITS(5)) u_c (
    .clk(clk), .rst(rst), .st(c_st), .sgn(c_sgn), .num(c_num),
    .busy(c_busy), .done(c_done), .bcd(c_bcd), .neg(c_neg), .ovf(c_ovf)
  );

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  function automatic int width_of(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic int digits_of(input int i);
    return (i == 0) ? 3 : ((i == 1) ? 2 : 5);
  endfunction

  function automatic logic done_of(input int i);
    return (i == 0) ? a_done : ((i == 1) ? b_done : c_done);
  endfunction

  function automatic logic busy_of(input int i);
    return (i == 0) ? a_busy : ((i == 1) ? b_busy : c_busy);
  endfunction

  // Decimal reference: magnitude from plain integer arithmetic, digits by repeated /10.
  function automatic exp_t model(input int w, input int d, input logic [15:0] n, input logic s);
    exp_t   e;
    longint m;
    e.bcd = '0;
    e.neg = s && n[w-1];
    m = longint'(n) & ((longint'(1) << w) - 1);
    if (e.neg) m = (longint'(1) << w) - m;
    for (int k = 0; k < d; k++) begin
      e.bcd[4*k +: 4] = 4'(m % 10);
      m = m / 10;
    end
    e.ovf = (m != 0);
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input int i, input exp_t e);
    case (i)
      0:       q0.push_back(e);
      1:       q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  task automatic drive(input int i, input logic s_t, input logic s, input logic [15:0] n);
    case (i)
      0:       begin a_st = s_t; a_sgn = s; a_num = n[7:0]; end
      1:       begin b_st = s_t; b_sgn = s; b_num = n[7:0]; end
      default: begin c_st = s_t; c_sgn = s; c_num = n; end
    endcase
  endtask

  task automatic check_out(input int i, input logic [63:0] b, input logic n, input logic o,
                           input logic bz);
    exp_t e;
    int   sz;
    sz = (i == 0) ? q0.size() : ((i == 1) ? q1.size() : q2.size());
    chk($sformatf("busy_with_done[%0d]", i), {63'b0, bz}, 64'd0);
    if (sz == 0) begin
      checks++;
      errors++;
      $display("FAIL unexpected_done[%0d]: got done=1 expected no pending result", i);
    end else begin
      case (i)
        0:       e = q0.pop_front();
        1:       e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("bcd[%0d]", i), b, e.bcd);
      chk($sformatf("neg[%0d]", i), {63'b0, n}, {63'b0, e.neg});
      chk($sformatf("ovf[%0d]", i), {63'b0, o}, {63'b0, e.ovf});
    end
  endtask

  always @(negedge clk) if (a_done) check_out(0, {52'b0, a_bcd}, a_neg, a_ovf, a_busy);
  always @(negedge clk) if (b_done) check_out(1, {56'b0, b_bcd}, b_neg, b_ovf, b_busy);
  always @(negedge clk) if (c_done) check_out(2, {44'b0, c_bcd}, c_neg, c_ovf, c_busy);

  // One conversion with latency/busy-length checks; operand is scrambled after the sample edge.
  task automatic conv(input int i, input logic [15:0] n, input logic s, input exp_t e);
    int lat;
    int bcnt;
    @(negedge clk);
    drive(i, 1'b1, s, n);
    @(posedge clk);
    #1 drive(i, 1'b0, ~s, ~n);
    push(i, e);
    lat  = -1;
    bcnt = 0;
    for (int k = 0; k <= 40; k++) begin
      @(negedge clk);
      if (busy_of(i)) bcnt++;
      if (done_of(i)) begin
        lat = k;
        break;
      end
    end
    chk($sformatf("latency[%0d]", i), 64'(lat), 64'(width_of(i)));
    chk($sformatf("busy_cycles[%0d]", i), 64'(bcnt), 64'(width_of(i)));
    @(negedge clk);
    chk($sformatf("done_one_cycle[%0d]", i), {63'b0, done_of(i)}, 64'd0);
  endtask

  task automatic conv_m(input int i, input logic [15:0] n, input logic s);
    conv(i, n, s, model(width_of(i), digits_of(i), n, s));
  endtask

  function automatic exp_t mk(input logic [63:0] b, input logic n, input logic o);
    exp_t e;
    e.bcd = b;
    e.neg = n;
    e.ovf = o;
    return e;
  endfunction

  initial begin
    int t[3];
    int ndone;
    logic [15:0] r;
    logic rs;

    // Reset state
    repeat (2) @(negedge clk);
    chk("reset_a", {a_bcd, a_neg, a_ovf, a_busy, a_done}, 64'd0);
    chk("reset_b", {b_bcd, b_neg, b_ovf, b_busy, b_done}, 64'd0);
    chk("reset_c", {c_bcd, c_neg, c_ovf, c_busy, c_done}, 64'd0);
    rst = 1'b0;

    // Directed cases
    conv(0, 16'd255, 1'b0, mk(64'h255, 1'b0, 1'b0));
    conv(0, 16'h00F6, 1'b1, mk(64'h010, 1'b1, 1'b0));
    conv(0, 16'h0080, 1'b1, mk(64'h128, 1'b1, 1'b0));
    conv(0, 16'h0000, 1'b1, mk(64'h000, 1'b0, 1'b0));
    conv(1, 16'd255, 1'b0, mk(64'h55, 1'b0, 1'b1));
    conv(1, 16'd99, 1'b0, mk(64'h99, 1'b0, 1'b0));
    conv(2, 16'd65535, 1'b0, mk(64'h65535, 1'b0, 1'b0));
    conv(2, 16'h8000, 1'b1, mk(64'h32768, 1'b1, 1'b0));

    // st pulsed mid-conversion must be ignored
    fork
      conv(0, 16'd123, 1'b0, mk(64'h123, 1'b0, 1'b0));
      begin
        repeat (4) @(negedge clk);
        a_st = 1'b1; a_num = 8'd7; a_sgn = 1'b0;
        @(negedge clk);
        a_st = 1'b0;
      end
    join
    repeat (12) @(negedge clk);

    // st held high: back-to-back conversions every WIDTH+2 cycles
    for (int j = 0; j < 3; j++) push(0, mk(64'h010, 1'b1, 1'b0));
    @(negedge clk);
    a_st = 1'b1; a_sgn = 1'b1; a_num = 8'hF6;
    for (int j = 0; j < 3; j++) begin
      t[j] = -1000;
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if (a_done) begin
          t[j] = cyc;
          break;
        end
      end
    end
    a_st = 1'b0;
    chk("period_1", 64'(t[1] - t[0]), 64'd10);
    chk("period_2", 64'(t[2] - t[1]), 64'd10);
    repeat (4) @(negedge clk);

    // Reset mid-conversion, previous result 255 is on the outputs
    conv(0, 16'd255, 1'b0, mk(64'h255, 1'b0, 1'b0));
    @(negedge clk);
    a_st = 1'b1; a_sgn = 1'b0; a_num = 8'd37;
    @(posedge clk);
    #1 a_st = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_conv", {52'b0, a_bcd, a_neg, a_ovf, a_busy, a_done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (a_done) ndone++;
      if (a_busy) ndone++;
    end
    chk("no_done_after_rst", 64'(ndone), 64'd0);
    conv(0, 16'd37, 1'b0, mk(64'h037, 1'b0, 1'b0));

    // Random operands against the reference model
    for (int j = 0; j < 1000; j++) begin
      r  = 16'($urandom_range(0, 65535));
      rs = 1'($urandom % 2);
      conv_m(2, r, rs);
    end
    for (int j = 0; j < 150; j++) begin
      r  = 16'($urandom_range(0, 255));
      rs = 1'($urandom % 2);
      conv_m(0, r, rs);
      conv_m(1, r, rs);
    end

    repeat (5) @(negedge clk);
    chk("queues_drained", 64'(q0.size() + q1.size() + q2.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_conv.md
# bin_to_bcd_conv

Parametrised sequential binary-to-BCD converter using shift-and-add-3, one bit per clock. Accepts an unsigned or two's-complement operand on a start strobe, reports busy and a one-cycle done pulse, and holds a registered BCD result, sign flag and overflow flag until the next conversion. Sits between arithmetic datapaths and the seven-segment and display drivers, and replaces fixed 8-bit / 3-digit conversion logic.

## Interface
- WIDTH, 8: binary operand width in bits, ≥ 2.
- DIGITS, 3: number of BCD output digits, ≥ 1. Undersizing is legal and is reported through ovf.
- clk  in  1: clock; all state updates on rising edge.
- rst  in  1: reset, asynchronous and active-high.
- st  in  1: start request, sampled only in IDLE.
- sgn  in  1: 1 = treat num as two's complement; 0 = unsigned. Sampled with st.
- num  in  WIDTH: operand, sampled with st.
- busy  out  1: high while converting (state CONV).
- done  out  1: one-cycle pulse when a new result is valid.
- bcd  out  4*DIGITS: result, digit k at bits [4k+3:4k], digit 0 = units. Registered.
- neg  out  1: result is negative (sgn=1 and num MSB=1). Registered.
- ovf  out  1: magnitude did not fit in DIGITS digits. Registered.

## Operation
- FSM states: IDLE, CONV, DONE.
  - IDLE: if st=1, go to CONV.
  - CONV: stay in CONV until WIDTH shift steps have been done, then go to DONE.
  - DONE: unconditionally go to IDLE.
- Load, on the IDLE edge with st=1:
  - mag ← (sgn && num[WIDTH-1]) ? (~num + 1) : num, computed in WIDTH bits. -2^(WIDTH-1) yields 2^(WIDTH-1), which is correct as an unsigned value.
  - Capture neg_r.
  - Clear the work BCD register (4*DIGITS bits), the overflow sticky bit and the step counter.
- Each CONV edge:
  - Every work digit ≥ 5 gets +3 (4-bit add, no carry between digits).
  - The adjusted vector shifts left by 1, with mag[WIDTH-1] entering bit 0.
  - mag shifts left by 1 and the counter increments.
  - The bit shifted out of the top of the adjusted vector ORs into the overflow sticky bit.
- On the edge that performs the final (WIDTH-th) shift:
  - bcd ← final work value.
  - ovf ← sticky OR the final shifted-out bit.
  - neg ← neg_r.
  - State becomes DONE.
- Outputs bcd, neg and ovf change only on that edge and hold until the next completion.
- When ovf=1, bcd holds the low DIGITS digits of the true result (truncated, with no saturation).
- st in CONV or DONE is ignored. It is neither queued nor aborting.
- Counter width is ⌈log2(WIDTH+1)⌉. No wrap is possible.

## Timing
- Reset values: state IDLE, busy=0, done=0, bcd=0, neg=0, ovf=0, and all work registers 0.
- Reset mid-conversion aborts immediately. Outputs return to 0 with no done pulse.
- Let edge E0 be the edge that samples st=1 in IDLE:
  - busy=1 from after E0 until after edge E_WIDTH.
  - Shifts occur at edges E1..E_WIDTH.
  - After E_WIDTH: done=1, busy=0, and bcd/neg/ovf are valid.
  - After E_(WIDTH+1): done=0 and state is IDLE; st is sampled again at E_(WIDTH+2).
- Latency from st sample to done is WIDTH cycles. Minimum start-to-start period is WIDTH+2 cycles.
- With st held high, conversions run back to back with that period.
- busy and done are never high simultaneously. done is high for exactly one cycle per conversion.
- num/sgn changes after E0 do not affect the running conversion.

## Test plan
- WIDTH=8, DIGITS=3, unsigned: num=255 → bcd=0x255, neg=0, ovf=0; done exactly 8 cycles after st is sampled; busy high for 8 cycles.
- WIDTH=8, DIGITS=3, signed: num=0xF6 → bcd=0x010, neg=1. Then num=0x80 → bcd=0x128, neg=1. Then num=0x00 → bcd=0x000, neg=0.
- WIDTH=8, DIGITS=2, unsigned: num=255 → ovf=1, bcd=0x55. Then num=99 → ovf=0, bcd=0x99.
- WIDTH=16, DIGITS=5: num=65535 → bcd=0x65535, done after 16 cycles. Also run 1000 random operands, each checked against a reference decimal model.
- Pulse st during CONV: no effect and the result matches the first operand. Hold st high: done pulses every WIDTH+2 cycles.
- Assert rst at the 4th CONV cycle: outputs read 0 immediately, no done pulse, state IDLE. The next st converts correctly.
